// File: rtl/priority_alarm_ctrl.sv
// Clocked N-channel priority alarm: edge-latched pending bits, masked priority
// report, operator ack/silence and a blinking alarm drive.
module priority_alarm_ctrl #(
    parameter int N         = 4,
    parameter int IDW       = 2,
    parameter int BLINK_DIV = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_alarm,
    input  logic [N-1:0]   in_mask,
    input  logic           in_ack,
    input  logic           in_silence,
    output logic           out_valid,
    output logic [IDW-1:0] out_id,
    output logic [N-1:0]   out_pending,
    output logic           out_alarm
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALERT,
        ST_SILENCE
    } state_t;

    logic [N-1:0]   r_in;
    logic [N-1:0]   r_in_d;
    logic [N-1:0]   r_pending;
    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic           r_phase;
    logic           r_alarm;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_eff;
    logic [N-1:0]   w_clr;
    logic           w_valid;
    logic [IDW-1:0] w_id;
    logic           w_new_evt;
    state_t         w_state_next;
    logic [CW-1:0]  w_cnt_next;
    logic           w_phase_next;

    assign w_edge    = r_in & ~r_in_d;
    assign w_eff     = r_pending & ~in_mask;
    assign w_valid   = |w_eff;
    assign w_new_evt = |(w_edge & ~in_mask);
    assign w_clr     = (in_ack && w_valid) ? (N'(1) << w_id) : '0;

    // Scan from the top down so the lowest-numbered channel is written last and wins.
    always_comb begin
        w_id = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_eff[i]) w_id = IDW'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_valid) w_state_next = ST_ALERT;
            end
            ST_ALERT: begin
                if (!w_valid)       w_state_next = ST_IDLE;
                else if (in_silence) w_state_next = ST_SILENCE;
            end
            ST_SILENCE: begin
                if (!w_valid)       w_state_next = ST_IDLE;
                else if (w_new_evt) w_state_next = ST_ALERT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        if (w_state_next == ST_ALERT) begin
            if (r_state != ST_ALERT) begin
                w_cnt_next   = '0;
                w_phase_next = 1'b1;
            end else if (r_cnt == CNT_MAX) begin
                w_cnt_next   = '0;
                w_phase_next = ~r_phase;
            end else begin
                w_cnt_next   = r_cnt + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Sync stages come out of reset as all-ones: inputs still held high
            // see no rising edge and are not re-latched after reset.
            r_in      <= '1;
            r_in_d    <= '1;
            r_pending <= '0;
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_phase   <= 1'b0;
            r_alarm   <= 1'b0;
        end else begin
            r_in      <= in_alarm;
            r_in_d    <= r_in;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_phase   <= w_phase_next;
            r_alarm   <= (w_state_next == ST_ALERT) && w_phase_next;
        end
    end

    assign out_valid   = w_valid;
    assign out_id      = w_id;
    assign out_pending = r_pending;
    assign out_alarm   = r_alarm;

endmodule

// File: tb/tb_priority_alarm_ctrl.sv
// Scoreboard bench for priority_alarm_ctrl: stimulus queues hand-computed
// expectations, a monitor compares them after each clock edge.
module tb_priority_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_alarm;
    logic [3:0] in_mask;
    logic       in_ack;
    logic       in_silence;
    logic       out_valid;
    logic [1:0] out_id;
    logic [3:0] out_pending;
    logic       out_alarm;

    priority_alarm_ctrl #(.N(4), .IDW(2), .BLINK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_alarm   (in_alarm),
        .in_mask    (in_mask),
        .in_ack     (in_ack),
        .in_silence (in_silence),
        .out_valid  (out_valid),
        .out_id     (out_id),
        .out_pending(out_pending),
        .out_alarm  (out_alarm)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] p;
        logic       v;
        logic [1:0] id;
        logic       al;
    } exp_t;

    exp_t exp_q[$];
    exp_t async_q[$];
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        check({e.tag, ".pending"}, 16'(out_pending), 16'(e.p));
        check({e.tag, ".valid"},   16'(out_valid),   16'(e.v));
        check({e.tag, ".id"},      16'(out_id),      16'(e.id));
        check({e.tag, ".alarm"},   16'(out_alarm),   16'(e.al));
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #2;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            check({e.tag, ".cycle"}, 16'(cyc), 16'(e.cyc));
            compare(e);
        end
    end

    always @(posedge rst) begin
        exp_t e;
        #1;
        if (async_q.size() > 0) begin
            e = async_q.pop_front();
            compare(e);
        end
    end

    task automatic step(input logic [3:0] a, input logic [3:0] m, input logic ack, input logic sil);
        in_alarm   = a;
        in_mask    = m;
        in_ack     = ack;
        in_silence = sil;
        @(negedge clk);
    endtask

    task automatic step_chk(input string tag, input logic [3:0] a, input logic [3:0] m,
                            input logic ack, input logic sil,
                            input logic [3:0] p, input logic v, input logic [1:0] id,
                            input logic al);
        exp_t e;
        e.cyc = cyc + 1; e.tag = tag; e.p = p; e.v = v; e.id = id; e.al = al;
        exp_q.push_back(e);
        step(a, m, ack, sil);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; in_alarm = '0; in_mask = '0; in_ack = 1'b0; in_silence = 1'b0;
        @(negedge clk);
        step_chk("reset", 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        rst = 1'b0;
        step_chk("post_rst", 4'h0, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        step(4'h0, 4'h0, 0, 0);

        // Held ch2: two-clock latency, 4-high/4-low blink, no re-latch while held.
        step_chk("held_t0", 4'b0100, 4'h0, 0, 0, 4'h0,    0, 2'd0, 0);
        step_chk("held_t1", 4'b0100, 4'h0, 0, 0, 4'b0100, 1, 2'd2, 0);
        for (int i = 0; i < 9; i++)
            step_chk($sformatf("blink%0d", i), 4'b0100, 4'h0, 0, 0, 4'b0100, 1, 2'd2, (i < 4 || i == 8));
        step_chk("held_ack",  4'b0100, 4'h0, 1, 0, 4'h0, 0, 2'd0, 1);
        step_chk("held_idle", 4'b0100, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        step_chk("held_norl", 4'b0100, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        step(4'h0, 4'h0, 0, 0);
        step(4'h0, 4'h0, 0, 0);

        // Pulses on ch3 then ch1, then two acks.
        step(4'b1000, 4'h0, 0, 0);
        step_chk("p3_set",  4'b0000, 4'h0, 0, 0, 4'b1000, 1, 2'd3, 0);
        step_chk("p3_alrt", 4'b0010, 4'h0, 0, 0, 4'b1000, 1, 2'd3, 1);
        step_chk("p1_set",  4'b0000, 4'h0, 0, 0, 4'b1010, 1, 2'd1, 1);
        step_chk("ack1",    4'b0000, 4'h0, 1, 0, 4'b1000, 1, 2'd3, 1);
        step_chk("ack2",    4'b0000, 4'h0, 1, 0, 4'b0000, 0, 2'd0, 1);
        step_chk("ack_idle",4'b0000, 4'h0, 0, 0, 4'b0000, 0, 2'd0, 0);
        step_chk("ack_nov", 4'b0000, 4'h0, 1, 1, 4'b0000, 0, 2'd0, 0);

        // Masked ch0 is latched but not reported until unmasked.
        step(4'b0001, 4'b0001, 0, 0);
        step_chk("msk_set", 4'b0000, 4'b0001, 0, 0, 4'b0001, 0, 2'd0, 0);
        step_chk("msk_ack", 4'b0000, 4'b0001, 1, 0, 4'b0001, 0, 2'd0, 0);
        step_chk("unmask",  4'b0000, 4'b0000, 0, 0, 4'b0001, 1, 2'd0, 1);
        step_chk("unmask2", 4'b0000, 4'b0000, 0, 0, 4'b0001, 1, 2'd0, 1);

        // Silence with ch2 pending, then a new ch0 edge re-arms the alarm.
        step(4'h0, 4'h0, 1, 0);
        step(4'h0, 4'h0, 0, 0);
        step(4'b0100, 4'h0, 0, 0);
        step(4'h0, 4'h0, 0, 0);
        step(4'h0, 4'h0, 0, 0);
        step_chk("silence", 4'h0,    4'h0, 0, 1, 4'b0100, 1, 2'd2, 0);
        step_chk("sil_hold",4'h0,    4'h0, 0, 1, 4'b0100, 1, 2'd2, 0);
        step_chk("sil_in0", 4'b0001, 4'h0, 0, 0, 4'b0100, 1, 2'd2, 0);
        step_chk("rearm",   4'h0,    4'h0, 0, 0, 4'b0101, 1, 2'd0, 1);

        // Ack of ch1 coincident with a new ch1 edge: set wins.
        step(4'h0, 4'h0, 1, 0);
        step(4'h0, 4'h0, 1, 0);
        step(4'h0, 4'h0, 0, 0);
        step(4'b0010, 4'h0, 0, 0);
        step(4'b0000, 4'h0, 0, 0);
        step(4'b0010, 4'h0, 0, 0);
        step_chk("setwin",  4'b0010, 4'h0, 1, 0, 4'b0010, 1, 2'd1, 1);
        step_chk("setwin2", 4'b0000, 4'h0, 0, 0, 4'b0010, 1, 2'd1, 1);

        // Async reset mid-blink with all inputs held; no re-latch afterwards.
        step(4'b1111, 4'h0, 0, 0);
        step(4'b1111, 4'h0, 0, 0);
        step(4'b1111, 4'h0, 0, 0);
        step(4'b1111, 4'h0, 0, 0);
        #1;
        e.cyc = 0; e.tag = "async_rst"; e.p = 4'h0; e.v = 0; e.id = 2'd0; e.al = 0;
        async_q.push_back(e);
        rst = 1'b1;
        @(negedge clk);
        step_chk("rst_hold", 4'b1111, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        rst = 1'b0;
        step_chk("norl0", 4'b1111, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        step_chk("norl1", 4'b1111, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        step_chk("norl2", 4'b1111, 4'h0, 0, 0, 4'h0, 0, 2'd0, 0);
        step(4'b1011, 4'h0, 0, 0);
        step(4'b1111, 4'h0, 0, 0);
        step_chk("retog",  4'b1111, 4'h0, 0, 0, 4'b0100, 1, 2'd2, 0);
        step_chk("retog2", 4'b1111, 4'h0, 0, 0, 4'b0100, 1, 2'd2, 1);

        step(4'h0, 4'h0, 0, 0);
        step(4'h0, 4'h0, 0, 0);
        check("leftover_expectations", 16'(exp_q.size() + async_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
